// File: rtl/uart_baud_gen.sv
// Programmable baud-rate tick generator: oversample tick, bit tick and phase.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen #(
    parameter int CLOCK_INPUT  = 50_000_000,
    parameter int BAUD_DEFAULT = 115_200,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic                          clock,
    input  logic                          nreset,
    input  logic                          ena,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          resync,
    output logic                          tick_os,
    output logic                          tick_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          div_err
);

    localparam int PH_W    = $clog2(OVERSAMPLE);
    localparam int DEF_RAW = CLOCK_INPUT / (BAUD_DEFAULT * OVERSAMPLE);
    localparam int DEF_INT = (DEF_RAW < 2) ? 2 : DEF_RAW;

    localparam logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(DEF_INT);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN     = DIV_W'(2);
    localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);

    logic [DIV_W-1:0] act_int_reg, act_int_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [PH_W-1:0]  phase_reg, phase_next;
    logic             div_err_reg, div_err_next;
    logic             tick_os_reg, tick_os_next;
    logic             tick_bit_reg, tick_bit_next;

    logic             carry;
    logic             load_low;
    logic [DIV_W-1:0] load_int;
    logic [DIV_W-1:0] cnt_reload;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] act_frac_reg, act_frac_next;
    logic [FRAC_W-1:0] acc_reg, acc_next;
    logic [FRAC_W:0]   acc_sum;

    // Carry-out of the phase accumulator stretches the period being reloaded.
    assign acc_sum = {1'b0, acc_reg} + {1'b0, act_frac_reg};
    assign carry   = acc_sum[FRAC_W];
`else
    logic unused_frac;

    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    assign load_low   = (div_int < DIV_MIN);
    assign load_int   = load_low ? DIV_MIN : div_int;
    assign cnt_reload = act_int_reg + {{(DIV_W-1){1'b0}}, carry} - DIV_ONE;

    always_comb begin
        act_int_next  = act_int_reg;
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        div_err_next  = div_err_reg;
        tick_os_next  = 1'b0;
        tick_bit_next = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        act_frac_next = act_frac_reg;
        acc_next      = acc_reg;
`endif
        if (div_load) begin
            act_int_next = load_int;
            div_err_next = load_low;
            cnt_next     = load_int - DIV_ONE;
            phase_next   = '0;
`ifdef UART_BAUD_FRAC_EN
            act_frac_next = div_frac;
            acc_next      = '0;
`endif
        end else if (resync) begin
            cnt_next   = act_int_reg - DIV_ONE;
            phase_next = '0;
`ifdef UART_BAUD_FRAC_EN
            acc_next = '0;
`endif
        end else if (ena) begin
            if (cnt_reg == '0) begin
                tick_os_next  = 1'b1;
                tick_bit_next = (phase_reg == PH_LAST);
                phase_next    = (phase_reg == PH_LAST) ? '0 : phase_reg + PH_ONE;
                cnt_next      = cnt_reload;
`ifdef UART_BAUD_FRAC_EN
                acc_next = acc_sum[FRAC_W-1:0];
`endif
            end else begin
                cnt_next = cnt_reg - DIV_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            act_int_reg  <= DIV_DEFAULT;
            cnt_reg      <= DIV_DEFAULT - DIV_ONE;
            phase_reg    <= '0;
            div_err_reg  <= 1'b0;
            tick_os_reg  <= 1'b0;
            tick_bit_reg <= 1'b0;
        end else begin
            act_int_reg  <= act_int_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            div_err_reg  <= div_err_next;
            tick_os_reg  <= tick_os_next;
            tick_bit_reg <= tick_bit_next;
        end
    end

`ifdef UART_BAUD_FRAC_EN
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            act_frac_reg <= '0;
            acc_reg      <= '0;
        end else begin
            act_frac_reg <= act_frac_next;
            acc_reg      <= acc_next;
        end
    end
`endif

    assign tick_os  = tick_os_reg;
    assign tick_bit = tick_bit_reg;
    assign os_phase = phase_reg;
    assign div_err  = div_err_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: tick schedule derived from closed-form
// cumulative period sums, compared against DUT ticks by a separate monitor.
module tb_uart_baud_gen;

    localparam int OS     = 16;
    localparam int FRAC_W = 4;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        resync = 1'b0;
    logic        tick_os, tick_bit, div_err;
    logic [3:0]  os_phase;

    uart_baud_gen dut (
        .clock    (clock),
        .nreset   (nreset),
        .ena      (ena),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .resync   (resync),
        .tick_os  (tick_os),
        .tick_bit (tick_bit),
        .os_phase (os_phase),
        .div_err  (div_err)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        longint     stamp;
        logic       bitt;
        logic [3:0] ph;
        logic       err;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: after a restart, tick j arrives once the count of
    // enabled cycles reaches j*int + floor((j-1)*frac / 2^FRAC_W).
    longint m_int = 27, m_frac = 0, m_e = 0, m_j = 1;
    logic   m_err = 1'b0;

    function automatic longint sched(longint j);
        return j * m_int + ((j - 1) * m_frac) / (longint'(1) << FRAC_W);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic step(input logic e, input logic ld, input logic [15:0] di,
                        input logic [3:0] df, input logic rs);
        exp_t x;
        @(negedge clock);
        ena = e; div_load = ld; div_int = di; div_frac = df; resync = rs;
        if (ld) begin
            m_int  = (di < 2) ? 2 : longint'(di);
            m_err  = (di < 2);
            m_frac = FRAC_ON ? longint'(df) : 0;
            m_e    = 0;
            m_j    = 1;
        end else if (rs) begin
            m_e = 0;
            m_j = 1;
        end else if (e) begin
            m_e++;
            if (m_e == sched(m_j)) begin
                x.stamp = cyc + 1;
                x.bitt  = (m_j % OS) == 0;
                x.ph    = 4'(m_j % OS);
                x.err   = m_err;
                q.push_back(x);
                m_j++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: every negedge, a tick must be present exactly when the
    // scoreboard front is stamped for this cycle.
    always @(negedge clock) begin
        exp_t f;
        logic want;
        while (q.size() > 0 && q[0].stamp < cyc) begin
            f = q.pop_front();
            chk("stale_tick", 32'(f.stamp), 32'(cyc));
        end
        want = (q.size() > 0) && (q[0].stamp == cyc);
        chk("tick_os", 32'(tick_os), 32'(want));
        if (want) begin
            f = q.pop_front();
            chk("tick_bit", 32'(tick_bit), 32'(f.bitt));
            chk("os_phase", 32'(os_phase), 32'(f.ph));
            chk("div_err", 32'(div_err), 32'(f.err));
        end else begin
            chk("tick_bit_idle", 32'(tick_bit), 32'(0));
        end
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        #1;
        chk("rst_tick_os", 32'(tick_os), 32'(0));
        chk("rst_tick_bit", 32'(tick_bit), 32'(0));
        chk("rst_os_phase", 32'(os_phase), 32'(0));
        chk("rst_div_err", 32'(div_err), 32'(0));
        repeat (3) @(negedge clock);
        nreset = 1'b1;

        run(60);                              // default divisor 27
        step(1'b1, 1'b1, 16'd4, 4'd0, 1'b0);  // integer divisor 4
        run(140);
        step(1'b1, 1'b1, 16'd4, 4'd8, 1'b0);  // fractional 4.5 (if enabled)
        run(160);

        step(1'b1, 1'b1, 16'd1, 4'd0, 1'b0);  // clamped to 2
        @(posedge clock); #1;
        chk("clamp_err", 32'(div_err), 32'(1));
        run(40);
        step(1'b1, 1'b1, 16'd6, 4'd0, 1'b0);
        @(posedge clock); #1;
        chk("clamp_clear", 32'(div_err), 32'(0));
        run(60);

        guard = 0;
        while (((m_j - 1) % OS) != 9 && guard < 500) begin
            run(1);
            guard++;
        end
        chk("phase9_reached", 32'((m_j - 1) % OS), 32'(9));
        @(posedge clock); #1;
        chk("phase9_seen", 32'(os_phase), 32'(9));
        step(1'b1, 1'b0, '0, '0, 1'b1);
        @(posedge clock); #1;
        chk("resync_phase", 32'(os_phase), 32'(0));
        chk("resync_notick", 32'(tick_os), 32'(0));
        run(3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        run(40);

        step(1'b1, 1'b1, 16'd5, 4'd0, 1'b1);  // load beats resync
        run(50);

        @(posedge clock); #2;
        nreset = 1'b0;
        #1;
        chk("async_tick_os", 32'(tick_os), 32'(0));
        chk("async_tick_bit", 32'(tick_bit), 32'(0));
        chk("async_os_phase", 32'(os_phase), 32'(0));
        chk("async_div_err", 32'(div_err), 32'(0));
        q.delete();
        ena = 1'b0; div_load = 1'b0; resync = 1'b0;
        m_int = 27; m_frac = 0; m_err = 1'b0; m_e = 0; m_j = 1;
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        run(60);

        for (int i = 0; i < 15000; i++) begin
            logic e, ld, rs;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(e, ld, 16'($urandom_range(0, 12)), 4'($urandom_range(0, 15)), rs);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clock); #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
